// File: rtl/seq_frame_sync.sv
// seq_frame_sync: hunt/verify/lock frame alignment behind a 12-bit sync-word detector.
// Keeps a flywheel bit counter, rides out up to MISS_MAX-1 missed syncs and flags payload starts.
// Optional macro SPUR_CNT_EN adds spur_cnt, a saturating count of off-position matches while locked.
module seq_frame_sync #(
  parameter int unsigned FRAME_LEN = 48,
  parameter int unsigned CONFIRM   = 2,
  parameter int unsigned MISS_MAX  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         det_in,
  input  logic                         clr,
  output logic [1:0]                   state,
  output logic                         locked,
  output logic                         frame_start,
  output logic                         lock_lost,
`ifdef SPUR_CNT_EN
  output logic [15:0]                  spur_cnt,
`endif
  output logic [$clog2(FRAME_LEN)-1:0] bit_pos
);

  localparam int unsigned BW = $clog2(FRAME_LEN);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } st_e;

  st_e           st;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  logic          exp_c;
  logic [BW-1:0] pos_next_c;
  logic [CW-1:0] hit_inc_c;
  logic [CW-1:0] miss_inc_c;

  assign state = st;

  // Expected-sync position and the free-running successor values
  always_comb begin
    exp_c      = (bit_pos == BW'(FRAME_LEN - 1));
    pos_next_c = exp_c ? '0 : bit_pos + BW'(1);
    hit_inc_c  = hit_cnt + CW'(1);
    miss_inc_c = miss_cnt + CW'(1);
  end

  // Alignment FSM with flywheel counter and registered status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= ST_HUNT;
      bit_pos     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
    end else if (clr) begin
      st          <= ST_HUNT;
      bit_pos     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      bit_pos     <= pos_next_c;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
      case (st)
        ST_HUNT: begin
          if (det_in) begin
            bit_pos <= '0;
            hit_cnt <= CW'(1);
            if (CONFIRM == 1) begin
              st          <= ST_LOCKED;
              locked      <= 1'b1;
              miss_cnt    <= '0;
              frame_start <= 1'b1;
            end else begin
              st <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          // Matches away from the expected position do not re-anchor
          if (exp_c) begin
            if (det_in) begin
              hit_cnt <= hit_inc_c;
              if (hit_inc_c == CW'(CONFIRM)) begin
                st          <= ST_LOCKED;
                locked      <= 1'b1;
                miss_cnt    <= '0;
                frame_start <= 1'b1;
              end
            end else begin
              st      <= ST_HUNT;
              hit_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (exp_c) begin
            if (det_in) begin
              miss_cnt    <= '0;
              frame_start <= 1'b1;
            end else if (miss_inc_c == CW'(MISS_MAX)) begin
              st        <= ST_HUNT;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              miss_cnt  <= '0;
              hit_cnt   <= '0;
            end else begin
              // Flywheel frame: sync missed but payload timing still trusted
              miss_cnt    <= miss_inc_c;
              frame_start <= 1'b1;
            end
          end
        end
        default: begin
          st     <= ST_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPUR_CNT_EN
  // Saturating count of off-position matches seen while locked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spur_cnt <= '0;
    end else if (clr) begin
      spur_cnt <= '0;
    end else if (st == ST_LOCKED && !exp_c && det_in && spur_cnt != 16'hFFFF) begin
      spur_cnt <= spur_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_frame_sync.sv
// Self-checking bench for seq_frame_sync with a per-cycle reference-model scoreboard.
// Define SPUR_CNT_EN for both files to exercise the spurious-match counter.
module tb_seq_frame_sync;

  localparam int unsigned FL = 48;
  localparam int unsigned CF = 2;
  localparam int unsigned MM = 3;
  localparam int unsigned BW = $clog2(FL);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          det_in = 1'b0;
  logic          clr = 1'b0;
  logic [1:0]    state;
  logic          locked;
  logic          frame_start;
  logic          lock_lost;
  logic [BW-1:0] bit_pos;
`ifdef SPUR_CNT_EN
  logic [15:0]   spur_cnt;
`endif

  seq_frame_sync #(.FRAME_LEN(FL), .CONFIRM(CF), .MISS_MAX(MM)) dut (
    .clk         (clk),
    .reset       (reset),
    .det_in      (det_in),
    .clr         (clr),
    .state       (state),
    .locked      (locked),
    .frame_start (frame_start),
    .lock_lost   (lock_lost),
`ifdef SPUR_CNT_EN
    .spur_cnt    (spur_cnt),
`endif
    .bit_pos     (bit_pos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic          lk;
    logic          fs;
    logic          ll;
    logic [BW-1:0] pos;
    logic [15:0]   sp;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fs_seen = 0;
  int ll_seen = 0;

  // Reference model state
  int m_st, m_pos, m_hit, m_miss, m_sp;
  bit m_fs, m_ll;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s @cyc%0d: got %0h want %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_st = 0; m_pos = 0; m_hit = 0; m_miss = 0; m_sp = 0; m_fs = 0; m_ll = 0;
  endtask

  // Advance the model by one clock and queue the outputs it predicts
  task automatic model_step(input bit d, input bit c);
    int  nst;
    int  npos;
    bit  ex;
    exp_t e;
    if (c) begin
      model_clear();
    end else begin
      ex   = (m_pos == FL - 1);
      npos = ex ? 0 : m_pos + 1;
      nst  = m_st;
      m_fs = 0;
      m_ll = 0;
      case (m_st)
        0: if (d) begin
             npos = 0; m_hit = 1;
             if (CF == 1) begin nst = 2; m_miss = 0; m_fs = 1; end
             else nst = 1;
           end
        1: if (ex) begin
             if (d) begin
               m_hit++;
               if (m_hit == CF) begin nst = 2; m_miss = 0; m_fs = 1; end
             end else begin
               nst = 0; m_hit = 0;
             end
           end
        default: if (ex) begin
             if (d) m_miss = 0; else m_miss++;
             if (m_miss == MM) begin nst = 0; m_ll = 1; m_miss = 0; m_hit = 0; end
             else m_fs = 1;
           end else if (d && m_sp < 65535) begin
             m_sp++;
           end
      endcase
      m_pos = npos;
      m_st  = nst;
    end
    e.st  = 2'(m_st);
    e.lk  = (m_st == 2);
    e.fs  = m_fs;
    e.ll  = m_ll;
    e.pos = BW'(m_pos);
    e.sp  = 16'(m_sp);
    sbq.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the queued prediction
  task automatic step(input bit d, input bit c);
    exp_t e;
    det_in = d;
    clr    = c;
    model_step(d, c);
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("locked", 32'(locked), 32'(e.lk));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("lock_lost", 32'(lock_lost), 32'(e.ll));
      chk("bit_pos", 32'(bit_pos), 32'(e.pos));
`ifdef SPUR_CNT_EN
      chk("spur_cnt", 32'(spur_cnt), 32'(e.sp));
`endif
    end
    fs_seen += int'(frame_start);
    ll_seen += int'(lock_lost);
  endtask

  // Assert reset between edges, check it acts at once, release after one edge
  task automatic do_reset(input string tag);
    reset  = 1'b0;
    det_in = 1'b0;
    clr    = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_pos"}, 32'(bit_pos), 32'd0);
    chk({tag, "_ll"}, 32'(lock_lost), 32'd0);
    sbq.delete();
    model_clear();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cyc     = 0;
    fs_seen = 0;
    ll_seen = 0;
  endtask

  initial begin
    #3;
    // Power-on reset and idle counting
    do_reset("t1_rst");
    chk("t1_fs0", 32'(frame_start), 32'd0);

    // Acquire lock, then lose it after three missed syncs
    for (int i = 0; i < 300; i++) begin
      step(cyc == 10 || cyc == 58 || cyc == 106, 1'b0);
      if (cyc == 3)   chk("t1_pos3", 32'(bit_pos), 32'd3);
      if (cyc == 11)  begin chk("t2_verify", 32'(state), 32'd1); chk("t2_pos0", 32'(bit_pos), 32'd0); end
      if (cyc == 59)  begin chk("t2_lock", 32'(state), 32'd2); chk("t2_fs59", 32'(frame_start), 32'd1); end
      if (cyc == 203) chk("t4_flywheel", 32'(locked), 32'd1);
      if (cyc == 251) begin chk("t4_hunt", 32'(state), 32'd0); chk("t4_ll", 32'(lock_lost), 32'd1); end
      if (cyc == 252) chk("t4_ll_off", 32'(lock_lost), 32'd0);
    end
    chk("t2_fs_count", 32'(fs_seen), 32'd4);
    chk("t4_ll_count", 32'(ll_seen), 32'd1);

    // Single sync only: verify fails back to hunt
    do_reset("t3_rst");
    for (int i = 0; i < 80; i++) begin
      step(cyc == 10, 1'b0);
      if (cyc == 11) chk("t3_verify", 32'(state), 32'd1);
      if (cyc == 59) chk("t3_hunt", 32'(state), 32'd0);
    end
    chk("t3_fs_none", 32'(fs_seen), 32'd0);

    // Spurious match while locked, then soft clear
    do_reset("t5_rst");
    for (int i = 0; i < 120; i++) begin
      step(cyc == 10 || cyc == 58 || cyc == 106 || cyc == 79, 1'b0);
      if (cyc == 80) begin
        chk("t5_state", 32'(state), 32'd2);
        chk("t5_pos", 32'(bit_pos), 32'd21);
`ifdef SPUR_CNT_EN
        chk("t5_spur1", 32'(spur_cnt), 32'd1);
`endif
      end
    end
`ifdef SPUR_CNT_EN
    for (int i = 0; i < 71600; i++) step(1'b1, 1'b0);
    chk("t5_spur_sat", 32'(spur_cnt), 32'hFFFF);
    chk("t5_still_locked", 32'(locked), 32'd1);
`endif
    step(1'b0, 1'b1);
    chk("t6_clr_state", 32'(state), 32'd0);
    chk("t6_clr_pos", 32'(bit_pos), 32'd0);
    chk("t6_clr_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("t6_clr_no_ll", 32'(ll_seen), 32'd0);

    // Soft clear coinciding with the third missed sync
    do_reset("t6b_rst");
    for (int i = 0; i < 260; i++) begin
      step(cyc == 10 || cyc == 58 || cyc == 106, cyc == 250);
      if (cyc == 251) begin chk("t6b_state", 32'(state), 32'd0); chk("t6b_ll", 32'(lock_lost), 32'd0); end
    end
    chk("t6b_fs_count", 32'(fs_seen), 32'd4);
    chk("t6b_ll_count", 32'(ll_seen), 32'd0);

    // Reset asserted mid-verify
    do_reset("t6c_rst");
    for (int i = 0; i < 30; i++) step(cyc == 10, 1'b0);
    chk("t6c_verify", 32'(state), 32'd1);
    do_reset("t6c_mid");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("t6c_no_ll", 32'(ll_seen), 32'd0);
    chk("t6c_pos", 32'(bit_pos), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
